picosoc_iobus: RTL and testbench

- Parametrised N-channel I/O bus fabric for the PicoSoC iomem space; replaces the single iomem_valid/iomem_ready port with NUM_SLAVES decoded slave channels.
- Sits between the picorv32 native memory interface and peripheral slaves.
- Adds a registered request/response FSM, per-channel base/mask decode, an unmapped-address error response, a bus timeout and sticky error capture.

---
 rtl/picosoc_iobus_if.sv | 33 +++
 rtl/picosoc_iobus.sv | 178 +++++++++++++++++
 tb/tb_picosoc_iobus.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/picosoc_iobus_if.sv
// Bus bundle between the picorv32 iomem master, the I/O fabric and its decoded slave channels.
// s_rdata packs channel i at [32*i+31:32*i].
interface picosoc_iobus_if #(
  parameter int NUM_SLAVES = 4
);
  logic                    mem_valid;
  logic                    mem_ready;
  logic [31:0]             mem_addr;
  logic [31:0]             mem_wdata;
  logic [3:0]              mem_wstrb;
  logic [31:0]             mem_rdata;
  logic [NUM_SLAVES-1:0]   s_valid;
  logic [NUM_SLAVES-1:0]   s_ready;
  logic [31:0]             s_addr;
  logic [31:0]             s_wdata;
  logic [3:0]              s_wstrb;
  logic [32*NUM_SLAVES-1:0] s_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  s_valid, s_addr, s_wdata, s_wstrb,
    output s_ready, s_rdata
  );

  modport fabric (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb, s_ready, s_rdata,
    output mem_ready, mem_rdata, s_valid, s_addr, s_wdata, s_wstrb
  );
endinterface

// File: rtl/picosoc_iobus.sv
// N-channel iomem fabric: base/mask decode, registered request/response FSM, sticky error capture.
// Define PICOSOC_IOBUS_TIMEOUT_EN to build the ACCESS timeout counter and timeout error.
module picosoc_iobus #(
  parameter int              NUM_SLAVES = 4,
  parameter logic [16*32-1:0] SLAVE_BASE = {16{32'h0}},
  parameter logic [16*32-1:0] SLAVE_MASK = {16{32'hFFFF_FF00}},
  parameter int              TIMEOUT    = 255,
  parameter logic [31:0]     ERR_RDATA  = 32'hDEAD_BEEF
) (
  input  logic                 clk,
  input  logic                 reset,
  picosoc_iobus_if.fabric      bus,
  input  logic                 err_clr,
  output logic                 err_flag,
  output logic [1:0]           err_code,
  output logic [31:0]          err_addr
);
  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_flag_q, err_flag_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [31:0]      err_addr_q, err_addr_d;

  logic [NUM_SLAVES-1:0] hit_vec;
  logic [31:0]           rdata_arr [NUM_SLAVES];
  logic                  hit_any;
  logic [SEL_W-1:0]      hit_idx;
  logic                  sel_ready;
  logic                  tmo_hit;
  logic                  err_set;
  logic [1:0]            err_new_code;
  logic [31:0]           err_new_addr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_chan
      assign hit_vec[gi]   = ((bus.mem_addr & SLAVE_MASK[32*gi +: 32]) ==
                              (SLAVE_BASE[32*gi +: 32] & SLAVE_MASK[32*gi +: 32]));
      assign rdata_arr[gi] = bus.s_rdata[32*gi +: 32];
    end
  endgenerate

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_any = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  assign sel_ready = bus.s_ready[sel_q];

`ifdef PICOSOC_IOBUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != ACCESS)
      cnt_d = '0;
    else if (!sel_ready && !tmo_hit && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rdata_d      = rdata_q;
    err_set      = 1'b0;
    err_new_code = 2'b00;
    err_new_addr = bus.mem_addr;
    case (state_q)
      IDLE: begin
        if (bus.mem_valid) begin
          if (hit_any) begin
            addr_d  = bus.mem_addr;
            wdata_d = bus.mem_wdata;
            wstrb_d = bus.mem_wstrb;
            sel_d   = hit_idx;
            state_d = ACCESS;
          end else begin
            rdata_d      = ERR_RDATA;
            err_set      = 1'b1;
            err_new_code = 2'b01;
            state_d      = RESP;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          rdata_d = rdata_arr[sel_q];
          state_d = RESP;
        end else if (tmo_hit) begin
          rdata_d      = ERR_RDATA;
          err_set      = 1'b1;
          err_new_code = 2'b10;
          err_new_addr = addr_q;
          state_d      = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A fresh error beats a simultaneous clear; otherwise the first error sticks.
    err_flag_d = err_flag_q;
    err_code_d = err_code_q;
    err_addr_d = err_addr_q;
    if (err_set && (!err_flag_q || err_clr)) begin
      err_flag_d = 1'b1;
      err_code_d = err_new_code;
      err_addr_d = err_new_addr;
    end else if (err_clr) begin
      err_flag_d = 1'b0;
      err_code_d = 2'b00;
      err_addr_d = 32'h0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      err_flag_q <= 1'b0;
      err_code_q <= 2'b00;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      err_flag_q <= err_flag_d;
      err_code_q <= err_code_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign bus.mem_ready = (state_q == RESP);
  assign bus.mem_rdata = rdata_q;
  assign bus.s_valid   = (state_q == ACCESS) ? (NUM_SLAVES'(1) << sel_q) : '0;
  assign bus.s_addr    = addr_q;
  assign bus.s_wdata   = wdata_q;
  assign bus.s_wstrb   = wstrb_q;
  assign err_flag      = err_flag_q;
  assign err_code      = err_code_q;
  assign err_addr      = err_addr_q;
endmodule

// File: tb/tb_picosoc_iobus.sv
// Bench for picosoc_iobus: directed vector table, multi-cycle corner sequences, and random
// transactions checked against a decode/latency/error-capture reference model.
module tb_picosoc_iobus;
  localparam int          NS   = 4;
  localparam int          TMO  = 8;
  localparam logic [31:0] ERRV = 32'hDEAD_BEEF;
`ifdef PICOSOC_IOBUS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  // ch3 0x03xxxxxx overlaps ch1 0x030000xx and ch2 0x030002xx; lower index wins.
  localparam logic [NS*32-1:0] BASE_P = {32'h0300_0000, 32'h0300_0200, 32'h0300_0000, 32'h0200_0000};
  localparam logic [NS*32-1:0] MASK_P = {32'hFF00_0000, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_0000};

  logic        clk = 1'b0;
  logic        reset;
  logic        err_clr;
  logic        err_flag;
  logic [1:0]  err_code;
  logic [31:0] err_addr;
  logic [31:0] slave_data [NS];

  int vec_cnt = 0;
  int miscmp  = 0;

  bit          m_flag;
  logic [1:0]  m_code;
  logic [31:0] m_eaddr;

  picosoc_iobus_if #(.NUM_SLAVES(NS)) bus ();

  picosoc_iobus #(
    .NUM_SLAVES (NS),
    .SLAVE_BASE ({{(16-NS){32'h0}}, BASE_P}),
    .SLAVE_MASK ({{(16-NS){32'hFFFF_FF00}}, MASK_P}),
    .TIMEOUT    (TMO),
    .ERR_RDATA  (ERRV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .err_clr  (err_clr),
    .err_flag (err_flag),
    .err_code (err_code),
    .err_addr (err_addr)
  );

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NS; gi++) begin : g_sdata
    assign bus.s_rdata[32*gi +: 32] = slave_data[gi];
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          delay;
    bit          clr;
    bit          noise;
    logic [31:0] sdata;
    int          ch;
    int          lat;
    logic [31:0] rdata;
    bit          flag;
    logic [1:0]  code;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vt [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & MASK_P[32*i +: 32]) == (BASE_P[32*i +: 32] & MASK_P[32*i +: 32])) return i;
    return -1;
  endfunction

  task automatic m_err_event(input logic [1:0] code, input logic [31:0] a, input bit clr);
    if (!m_flag || clr) begin
      m_flag  = 1'b1;
      m_code  = code;
      m_eaddr = a;
    end
  endtask

  // Drives one request and plays the slave; ready goes to exp_ch in ACCESS cycle delay+1.
  task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                        input int delay, input bit clr, input bit noise, input int exp_ch,
                        input int exp_acc, output int lat, output logic [31:0] rd,
                        output bit bus_ok, output logic [34:0] errs);
    int acc;
    bit done;
    acc = 0; done = 1'b0; lat = -1; rd = '0; bus_ok = 1'b1; errs = '0;
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = wstrb;
    bus.s_ready   = '0;
    err_clr       = clr;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(negedge clk);
      err_clr = 1'b0;
      if (bus.s_valid != '0) begin
        acc++;
        if (exp_ch < 0 || bus.s_valid !== (NS'(1) << exp_ch)) bus_ok = 1'b0;
        if (bus.s_addr !== addr || bus.s_wdata !== wdata || bus.s_wstrb !== wstrb) bus_ok = 1'b0;
      end
      if (bus.mem_ready) begin
        if (bus.s_valid != '0) bus_ok = 1'b0;
        lat           = cyc;
        rd            = bus.mem_rdata;
        errs          = {err_flag, err_code, err_addr};
        bus.mem_valid = 1'b0;
        bus.s_ready   = '0;
        done          = 1'b1;
      end else begin
        bus.s_ready = noise ? '1 : '0;
        if (exp_ch >= 0) bus.s_ready[exp_ch] = (acc == delay + 1);
      end
    end
    if (!done) begin
      bus.mem_valid = 1'b0;
      bus.s_ready   = '0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_flag = 1'b0; m_code = 2'b00; m_eaddr = '0;
    end else begin
      if (acc != exp_acc) bus_ok = 1'b0;
      @(negedge clk);
      if (bus.mem_ready !== 1'b0) bus_ok = 1'b0;
    end
  endtask

  task automatic run_chk(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int delay, input bit clr, input bit noise,
                         input int ch, input int acc, input int lat, input logic [31:0] rdata,
                         input logic [34:0] errs);
    int          got_lat;
    logic [31:0] got_rd;
    bit          ok;
    logic [34:0] got_errs;
    do_txn(addr, wdata, wstrb, delay, clr, noise, ch, acc, got_lat, got_rd, ok, got_errs);
    $display("txn %s addr=%h wstrb=%b ch=%0d lat=%0d rdata=%h err=%h", name, addr, wstrb, ch,
             got_lat, got_rd, got_errs);
    check({name, " latency"}, 64'(got_lat), 64'(lat));
    check({name, " rdata"},   64'(got_rd),  64'(rdata));
    check({name, " bus"},     64'(ok),      64'(1));
    check({name, " err"},     64'(got_errs), 64'(errs));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ch, acc, lat;
    logic [31:0] a, wd, rd;
    logic [3:0]  ws;
    int          dly;
    bit          clr, noise, tmo;

    reset = 1'b1; err_clr = 1'b0;
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_wstrb = '0;
    bus.s_ready = '0;
    for (int j = 0; j < NS; j++) slave_data[j] = '0;
    m_flag = 1'b0; m_code = 2'b00; m_eaddr = '0;

    vt[0] = '{32'h0300_0204, 32'h0, 4'b0000, 0, 1'b0, 1'b0, 32'h1234_5678, 2, 2, 32'h1234_5678, 1'b0, 2'b00, 32'h0};
    vt[1] = '{32'h0200_0010, 32'hA5A5_0000, 4'b1100, 5, 1'b0, 1'b0, 32'h0BAD_F00D, 0, 7, 32'h0BAD_F00D, 1'b0, 2'b00, 32'h0};
    vt[2] = '{32'h0F00_0000, 32'h0, 4'b0000, 0, 1'b0, 1'b0, 32'h0, -1, 1, ERRV, 1'b1, 2'b01, 32'h0F00_0000};
    vt[3] = '{32'h0300_0000, 32'h0, 4'b0000, 2, 1'b0, 1'b1, 32'h5555_AAAA, 1, 4, 32'h5555_AAAA, 1'b1, 2'b01, 32'h0F00_0000};
    vt[4] = '{32'h0E00_0000, 32'h1111_2222, 4'b1111, 0, 1'b0, 1'b0, 32'h0, -1, 1, ERRV, 1'b1, 2'b01, 32'h0F00_0000};
    vt[5] = '{32'h03AB_CDEF, 32'hCAFE_F00D, 4'b1111, 1, 1'b1, 1'b0, 32'h7777_0001, 3, 3, 32'h7777_0001, 1'b0, 2'b00, 32'h0};
    vt[6] = '{32'h0E00_0000, 32'h0, 4'b0000, 0, 1'b1, 1'b0, 32'h0, -1, 1, ERRV, 1'b1, 2'b01, 32'h0E00_0000};
    vt[7] = '{32'h1000_0000, 32'h0, 4'b0000, 0, 1'b1, 1'b0, 32'h0, -1, 1, ERRV, 1'b1, 2'b01, 32'h1000_0000};

    repeat (3) @(negedge clk);
    check("reset bus",  {23'h0, bus.mem_ready, bus.s_valid, bus.s_wstrb, bus.mem_rdata}, 64'h0);
    check("reset data", {bus.s_addr, bus.s_wdata}, 64'h0);
    check("reset err",  64'({err_flag, err_code, err_addr}), 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < NS; j++) slave_data[j] = 32'hC0DE_0000 | 32'(j);
      if (vt[i].ch >= 0) slave_data[vt[i].ch] = vt[i].sdata;
      run_chk($sformatf("vec%0d", i), vt[i].addr, vt[i].wdata, vt[i].wstrb, vt[i].delay,
              vt[i].clr, vt[i].noise, vt[i].ch, (vt[i].ch < 0) ? 0 : vt[i].delay + 1,
              vt[i].lat, vt[i].rdata, {vt[i].flag, vt[i].code, vt[i].eaddr});
    end

`ifdef PICOSOC_IOBUS_TIMEOUT_EN
    run_chk("tmo_sticky", 32'h0200_0100, 32'h0, 4'b0000, 1000, 1'b0, 1'b0, 0, TMO, TMO + 1, ERRV,
            {1'b1, 2'b01, 32'h1000_0000});
    run_chk("tmo_clrset", 32'h0E00_0000, 32'h0, 4'b0000, 0, 1'b1, 1'b0, -1, 0, 1, ERRV,
            {1'b1, 2'b01, 32'h0E00_0000});
    run_chk("tmo_code", 32'h0300_0010, 32'h0, 4'b0000, 1000, 1'b1, 1'b0, 1, TMO, TMO + 1, ERRV,
            {1'b1, 2'b10, 32'h0300_0010});
    slave_data[2] = 32'h2468_ACE0;
    run_chk("tmo_edge", 32'h0300_0220, 32'h0, 4'b0000, TMO - 1, 1'b0, 1'b0, 2, TMO, TMO + 1,
            32'h2468_ACE0, {1'b1, 2'b10, 32'h0300_0010});
`endif

    // Asynchronous reset while channel 0 is mid-access.
    @(negedge clk);
    bus.mem_valid = 1'b1; bus.mem_addr = 32'h0200_0000; bus.mem_wstrb = 4'b0000; bus.s_ready = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst pre s_valid", 64'(bus.s_valid), 64'(4'b0001));
    #2 reset = 1'b1;
    #1 check("rst async", {24'h0, bus.s_valid, bus.mem_ready, err_flag, err_code, bus.s_addr}, 64'h0);
    @(negedge clk);
    bus.mem_valid = 1'b0;
    reset = 1'b0;
    slave_data[2] = 32'h0A0B_0C0D;
    run_chk("rst after", 32'h0300_0208, 32'h0, 4'b0000, 0, 1'b0, 1'b0, 2, 1, 2, 32'h0A0B_0C0D, 35'h0);
    m_flag = 1'b0; m_code = 2'b00; m_eaddr = '0;

    for (int n = 0; n < 60; n++) begin
      for (int j = 0; j < NS; j++) slave_data[j] = $urandom;
      case ($urandom_range(0, 4))
        0:       a = {16'h0200, 16'($urandom)};
        1:       a = {24'h03_0000, 8'($urandom)};
        2:       a = {24'h03_0002, 8'($urandom)};
        3:       a = {8'h03, 24'($urandom)};
        default: a = $urandom;
      endcase
      wd    = $urandom;
      ws    = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      dly   = $urandom_range(0, TMO_EN ? 9 : 5);
      clr   = ($urandom_range(0, 5) == 0);
      noise = $urandom_range(0, 1) == 1;
      ch    = decode(a);
      tmo   = (ch >= 0) && TMO_EN && (dly + 1 > TMO);
      if (ch < 0) begin
        acc = 0; lat = 1; rd = ERRV;
        m_err_event(2'b01, a, clr);
      end else begin
        if (clr) begin
          m_flag = 1'b0; m_code = 2'b00; m_eaddr = '0;
        end
        if (tmo) begin
          acc = TMO; lat = TMO + 1; rd = ERRV;
          m_err_event(2'b10, a, 1'b0);
        end else begin
          acc = dly + 1; lat = dly + 2; rd = slave_data[ch];
        end
      end
      run_chk($sformatf("rnd%0d", n), a, wd, ws, dly, clr, noise, ch, acc, lat, rd,
              {m_flag, m_code, m_eaddr});
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end
endmodule
